// File: rtl/divider.sv
// ============================================================================
// Module   : divider
// Brief    : Multi-cycle restoring integer divider, signed/unsigned, 32-bit bus
// Revision : 1.0
// ============================================================================
`default_nettype none

module divider #(
    parameter int DATA_WIDTH = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic        sign_mode,
    input  logic [31:0] operand_1,
    input  logic [31:0] operand_2,
    output logic        busy,
    output logic        done,
    output logic [31:0] quotient,
    output logic [31:0] remainder
);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_ITER = 2'd1;
    localparam logic [1:0] c_FIX  = 2'd2;
    localparam logic [4:0] c_LAST = 5'(DATA_WIDTH - 1);

    logic [1:0]            state_q, state_d;
    logic [4:0]            count_q;
    logic                  sign_q, qneg_q, rneg_q, dz_q;
    logic [DATA_WIDTH-1:0] div_q, rem_q, quo_q;
    logic                  busy_q, busy_d, done_q, done_d;
    logic [31:0]           quotient_q, quotient_d, remainder_q, remainder_d;

    logic [DATA_WIDTH-1:0] w_op1, w_op2, w_op1_abs, w_op2_abs, w_q_fix, w_r_fix;
    logic [DATA_WIDTH:0]   w_shift, w_trial;
    logic                  w_op2_zero;
    logic                  w_unused;

    function automatic logic [31:0] f_ext(input logic [DATA_WIDTH-1:0] v, input logic s);
        return s ? {{(32-DATA_WIDTH){v[DATA_WIDTH-1]}}, v} : {{(32-DATA_WIDTH){1'b0}}, v};
    endfunction

    assign w_op1      = operand_1[DATA_WIDTH-1:0];
    assign w_op2      = operand_2[DATA_WIDTH-1:0];
    assign w_unused   = ^{operand_1[31:DATA_WIDTH], operand_2[31:DATA_WIDTH]};
    assign w_op2_zero = (w_op2 == '0);
    assign w_op1_abs  = (sign_mode && w_op1[DATA_WIDTH-1]) ? -w_op1 : w_op1;
    assign w_op2_abs  = (sign_mode && w_op2[DATA_WIDTH-1]) ? -w_op2 : w_op2;

    // Shifted partial remainder needs one extra bit; the trial's MSB is its sign.
    assign w_shift = {rem_q, quo_q[DATA_WIDTH-1]};
    assign w_trial = w_shift - {1'b0, div_q};
    assign w_q_fix = qneg_q ? -quo_q : quo_q;
    assign w_r_fix = rneg_q ? -rem_q : rem_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= c_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            c_IDLE:  if (enable) state_d = w_op2_zero ? c_FIX : c_ITER;
            c_ITER:  if (count_q == c_LAST) state_d = c_FIX;
            c_FIX:   state_d = c_IDLE;
            default: state_d = c_IDLE;
        endcase
    end

    always_comb begin
        busy_d      = (state_d != c_IDLE);
        done_d      = (state_q == c_FIX);
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        if (state_q == c_FIX) begin
            if (dz_q) begin
                quotient_d  = f_ext({DATA_WIDTH{1'b1}}, sign_q);
                remainder_d = f_ext(quo_q, sign_q);
            end else begin
                quotient_d  = f_ext(w_q_fix, sign_q);
                remainder_d = f_ext(w_r_fix, sign_q);
            end
        end
    end

    // On divide-by-zero the quotient register carries the raw dividend to FIX.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
            sign_q  <= 1'b0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
            dz_q    <= 1'b0;
            div_q   <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
        end else begin
            case (state_q)
                c_IDLE: begin
                    if (enable) begin
                        sign_q  <= sign_mode;
                        qneg_q  <= sign_mode & (w_op1[DATA_WIDTH-1] ^ w_op2[DATA_WIDTH-1]);
                        rneg_q  <= sign_mode & w_op1[DATA_WIDTH-1];
                        dz_q    <= w_op2_zero;
                        div_q   <= w_op2_abs;
                        rem_q   <= '0;
                        quo_q   <= w_op2_zero ? w_op1 : w_op1_abs;
                        count_q <= '0;
                    end
                end
                c_ITER: begin
                    rem_q   <= w_trial[DATA_WIDTH] ? w_shift[DATA_WIDTH-1:0] : w_trial[DATA_WIDTH-1:0];
                    quo_q   <= {quo_q[DATA_WIDTH-2:0], ~w_trial[DATA_WIDTH]};
                    count_q <= count_q + 5'd1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
        end else begin
            busy_q      <= busy_d;
            done_q      <= done_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign quotient  = quotient_q;
    assign remainder = remainder_q;

endmodule

`default_nettype wire

// File: tb/tb_divider.sv
// ============================================================================
// Module   : tb_divider
// Brief    : Directed scoreboard bench for the multi-cycle divider
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_divider;

    logic        clk = 1'b0;
    logic        reset, enable, sign_mode;
    logic [31:0] operand_1, operand_2;
    logic        busy, done;
    logic [31:0] quotient, remainder;

    int          checks = 0;
    int          errors = 0;
    int          cycle = 0;
    int          busy_cyc = 0;
    int          t_cap, b_cap;
    logic [63:0] sb[$];
    logic [31:0] last_q, last_r;

    divider #(.DATA_WIDTH(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .enable    (enable),
        .sign_mode (sign_mode),
        .operand_1 (operand_1),
        .operand_2 (operand_2),
        .busy      (busy),
        .done      (done),
        .quotient  (quotient),
        .remainder (remainder)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cycle <= cycle + 1;
    always @(negedge clk) if (busy === 1'b1) busy_cyc <= busy_cyc + 1;

    // Reference results computed directly with SV integer arithmetic.
    function automatic logic [63:0] model(input logic sm, input logic [31:0] a32, input logic [31:0] b32);
        logic [7:0] a = a32[7:0];
        logic [7:0] b = b32[7:0];
        int sa, sbv, q, r;
        if (sm) begin
            sa  = int'($signed(a));
            sbv = int'($signed(b));
            if (sbv == 0) begin
                q = -1; r = sa;
            end else if (sa == -128 && sbv == -1) begin
                q = -128; r = 0;
            end else begin
                q = sa / sbv; r = sa % sbv;
            end
        end else begin
            sa  = int'(a);
            sbv = int'(b);
            if (sbv == 0) begin
                q = 255; r = sa;
            end else begin
                q = sa / sbv; r = sa % sbv;
            end
        end
        return {32'(q), 32'(r)};
    endfunction

    task automatic check(input string tag, input string what, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s %s: observed=%h expected=%h", tag, what, got, exp);
        end
    endtask

    task automatic start(input logic sm, input logic [31:0] a, input logic [31:0] b, input bit push, input bit hold);
        @(negedge clk);
        sign_mode = sm;
        operand_1 = a;
        operand_2 = b;
        enable    = 1'b1;
        if (push) sb.push_back(model(sm, a, b));
        @(posedge clk);
        #1;
        t_cap = cycle;
        b_cap = busy_cyc;
        if (!hold) enable = 1'b0;
    endtask

    task automatic finish_op(input string tag, input int lat, input int bsy);
        logic [63:0] exp;
        for (int i = 0; i < 40 && done !== 1'b1; i++) begin
            @(posedge clk);
            #1;
        end
        check(tag, "done", {31'b0, done}, 32'd1);
        check(tag, "latency", 32'(cycle - t_cap), 32'(lat));
        check(tag, "busy_cycles", 32'(busy_cyc - b_cap), 32'(bsy));
        check(tag, "busy_in_done", {31'b0, busy}, 32'd0);
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL %s scoreboard: observed=empty expected=entry", tag);
        end else begin
            exp    = sb.pop_front();
            last_q = exp[63:32];
            last_r = exp[31:0];
            check(tag, "quotient", quotient, last_q);
            check(tag, "remainder", remainder, last_r);
        end
    endtask

    initial begin
        reset     = 1'b1;
        enable    = 1'b0;
        sign_mode = 1'b0;
        operand_1 = '0;
        operand_2 = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset", "busy", {31'b0, busy}, 32'd0);
        check("reset", "done", {31'b0, done}, 32'd0);
        check("reset", "quotient", quotient, 32'd0);
        check("reset", "remainder", remainder, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        start(1'b0, 32'h0000_00C8, 32'h0000_0007, 1, 0); finish_op("u200/7", 9, 9);
        start(1'b1, 32'h0000_00F9, 32'h0000_0002, 1, 0); finish_op("s-7/2", 9, 9);
        start(1'b1, 32'h0000_0007, 32'h0000_00FE, 1, 0); finish_op("s7/-2", 9, 9);
        start(1'b1, 32'h0000_0080, 32'h0000_00FF, 1, 0); finish_op("s_ovf", 9, 9);
        start(1'b1, 32'h0000_0085, 32'h0000_0000, 1, 0); finish_op("s_dz", 1, 1);
        start(1'b0, 32'h0000_0085, 32'h0000_0000, 1, 0); finish_op("u_dz", 1, 1);
        start(1'b0, 32'hDEAD_BEFF, 32'h1234_5603, 1, 0); finish_op("u_hibits", 9, 9);
        start(1'b0, 32'h0000_0005, 32'h0000_0009, 1, 0); finish_op("u5/9", 9, 9);
        start(1'b1, 32'h0000_0080, 32'h0000_0001, 1, 0); finish_op("s-128/1", 9, 9);

        // Enable pulse with new operands while busy must be ignored.
        start(1'b0, 32'h0000_0064, 32'h0000_000A, 1, 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        enable    = 1'b1;
        sign_mode = 1'b1;
        operand_1 = 32'h0000_0011;
        operand_2 = 32'h0000_0003;
        @(negedge clk);
        enable = 1'b0;
        finish_op("ignore_en", 9, 9);

        // Enable held through the done cycle: second op starts without a gap.
        start(1'b0, 32'h0000_00F0, 32'h0000_000C, 1, 1);
        sign_mode = 1'b1;
        operand_1 = 32'h0000_002F;
        operand_2 = 32'h0000_00FB;
        sb.push_back(model(1'b1, operand_1, operand_2));
        finish_op("b2b_A", 9, 9);
        @(posedge clk);
        #1;
        t_cap  = cycle;
        b_cap  = busy_cyc;
        enable = 1'b0;
        check("b2b_B", "done_drop", {31'b0, done}, 32'd0);
        check("b2b_B", "busy_start", {31'b0, busy}, 32'd1);
        check("b2b_B", "q_stable", quotient, last_q);
        check("b2b_B", "r_stable", remainder, last_r);
        finish_op("b2b_B", 9, 9);

        // Asynchronous reset at iteration count 4 discards the partial result.
        start(1'b0, 32'h0000_00FA, 32'h0000_0005, 0, 0);
        repeat (4) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        check("mid_reset", "busy", {31'b0, busy}, 32'd0);
        check("mid_reset", "done", {31'b0, done}, 32'd0);
        check("mid_reset", "quotient", quotient, 32'd0);
        check("mid_reset", "remainder", remainder, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        start(1'b1, 32'h0000_009C, 32'h0000_0007, 1, 0); finish_op("post_reset", 9, 9);

        check("end", "sb_left", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
